// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths, index type and priority-select helper for the 4-to-2 encoder.
package encoder_pkg;
   localparam int ENC_IN_W  = 4;
   localparam int ENC_IDX_W = 2;
   typedef logic [ENC_IDX_W-1:0] enc_idx_t;
   localparam enc_idx_t ENC_IDX_RST = 2'b00;
   // later hits overwrite earlier ones, so scan order picks the winner
   function automatic enc_idx_t enc_prio(input logic [0:ENC_IN_W-1] v, input logic high);
      enc_prio = ENC_IDX_RST;
      for (int i = 0; i < ENC_IN_W; i++)
         if (v[high ? i : ENC_IN_W-1-i]) enc_prio = enc_idx_t'(high ? i : ENC_IN_W-1-i);
   endfunction
endpackage

// File: rtl/encoder_4to2_core.sv
// encoder_4to2_core: combinational priority encode; multi-hot flag only with ENCODER_4TO2_ERR_EN.
module encoder_4to2_core
   import encoder_pkg::*;
#(
   parameter int PRIORITY_HIGH = 1
) (
   input  logic [0:ENC_IN_W-1]  in,
   output logic [0:ENC_IDX_W-1] e,
   output logic                 valid,
   output logic                 err
);
   always_comb begin
      e     = enc_prio(in, PRIORITY_HIGH != 0);
      valid = |in;
`ifdef ENCODER_4TO2_ERR_EN
      err   = $countones(in) > 1;
`else
      err   = 1'b0;
`endif
   end
endmodule

// File: rtl/encoder_4to2_sync.sv
// encoder_4to2_sync: registered 4-to-2 priority encoder with valid/multi-hot flags.
// err detection is compiled in only when ENCODER_4TO2_ERR_EN is defined.
module encoder_4to2_sync
   import encoder_pkg::*;
#(
   parameter int PRIORITY_HIGH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [0:ENC_IN_W-1]  in,
   output logic [0:ENC_IDX_W-1] e,
   output logic                 valid,
   output logic                 err
);
   logic [0:ENC_IDX_W-1] e_c;
   logic                 valid_c;
   logic                 err_c;

   encoder_4to2_core #(.PRIORITY_HIGH(PRIORITY_HIGH)) u_core (
      .in(in),
      .e(e_c),
      .valid(valid_c),
      .err(err_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         e     <= ENC_IDX_RST;
         valid <= 1'b0;
         err   <= 1'b0;
      end else if (en) begin
         e     <= e_c;
         valid <= valid_c;
         err   <= err_c;
      end
   end
endmodule

// File: tb/tb_encoder_4to2_sync.sv
// tb_encoder_4to2_sync: scoreboard bench covering both priority settings side by side.
module tb_encoder_4to2_sync;
   typedef struct packed {
      logic [1:0] eh;
      logic [1:0] el;
      logic       v;
      logic       er;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] in_v = 4'b0000;
   logic [1:0] e_hi, e_lo;
   logic       valid_hi, valid_lo, err_hi, err_lo;
   exp_t       sb[$];
   exp_t       m = '0;
   int         n = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   encoder_4to2_sync #(.PRIORITY_HIGH(1)) dut_hi (
      .clk(clk), .rst(rst), .en(en), .in(in_v), .e(e_hi), .valid(valid_hi), .err(err_hi)
   );
   encoder_4to2_sync #(.PRIORITY_HIGH(0)) dut_lo (
      .clk(clk), .rst(rst), .en(en), .in(in_v), .e(e_lo), .valid(valid_lo), .err(err_lo)
   );

   // v[3-i] is in[i]; highest-numbered set bit wins
   function automatic logic [1:0] ref_hi(input logic [3:0] v);
      if (v[0]) return 2'd3;
      if (v[1]) return 2'd2;
      if (v[2]) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [1:0] ref_lo(input logic [3:0] v);
      if (v[3]) return 2'd0;
      if (v[2]) return 2'd1;
      if (v[1]) return 2'd2;
      if (v[0]) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic ref_err(input logic [3:0] v);
`ifdef ENCODER_4TO2_ERR_EN
      int c = 0;
      for (int i = 0; i < 4; i++) c += int'(v[i]);
      return c >= 2;
`else
      return 1'b0;
`endif
   endfunction

   task automatic cmp(input string tag, input logic [1:0] got, input logic [1:0] want);
      n++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s in=%b observed=%b expected=%b", tag, in_v, got, want);
      end
   endtask

   task automatic check();
      exp_t x;
      x = sb.pop_front();
      cmp("e_hi", e_hi, x.eh);
      cmp("e_lo", e_lo, x.el);
      cmp("valid_hi", {1'b0, valid_hi}, {1'b0, x.v});
      cmp("valid_lo", {1'b0, valid_lo}, {1'b0, x.v});
      cmp("err_hi", {1'b0, err_hi}, {1'b0, x.er});
      cmp("err_lo", {1'b0, err_lo}, {1'b0, x.er});
   endtask

   task automatic step(input logic [3:0] v, input logic en_v, input logic rst_v);
      @(negedge clk);
      in_v = v;
      en   = en_v;
      rst  = rst_v;
      @(posedge clk);
      if (rst_v) m = '0;
      else if (en_v) m = '{ref_hi(v), ref_lo(v), |v, ref_err(v)};
      sb.push_back(m);
      #1;
      check();
   endtask

   initial begin
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(4'(i), 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b0);
      step(4'b0110, 1'b1, 1'b0);
      step(4'b0001, 1'b1, 1'b0);
      @(negedge clk);
      in_v = 4'b1000;
      #2;
      cmp("latency_e_hi", e_hi, m.eh);
      cmp("latency_e_lo", e_lo, m.el);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0101, 1'b1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule

// File: doc/encoder_4to2_sync.md
# encoder_4to2_sync

Registered 4-to-2 priority encoder with valid and multi-hot flags, used wherever a 4-bit request/one-hot vector must be reduced to a 2-bit index. Input is sampled on the clock edge and the encoded index, valid and error flags are presented from registers one cycle later. A combinational encode core is wrapped by an enable-gated output register stage with synchronous reset.

## Interface
Parameters:
- PRIORITY_HIGH, default 1: 1 = in[3] has highest priority; 0 = in[0] has highest priority.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- en  input  1  sample enable; outputs update only when high.
- in  input  4, declared [0:3]  request vector; in[0] is the MSB when driven from an integer.
- e  output  2, declared [0:1]  encoded index; e[0] is MSB.
- valid  output  1  at least one input bit was set in the sampled vector.
- err  output  1  more than one input bit was set (multi-hot); see Configuration.

## Operation
- Index numbering: bit in[i] encodes to value i, i.e. e = i with e[0] = i[1], e[1] = i[0].
- PRIORITY_HIGH=1: e = largest i with in[i]=1. PRIORITY_HIGH=0: e = smallest such i.
- One-hot inputs encode identically under both priorities: 4'b1000 -> e=2'b00, 4'b0100 -> 01, 4'b0010 -> 10, 4'b0001 -> 11 (vectors written in[0..3]).
- in = 4'b0000: e = 2'b00, valid = 0, err = 0.
- valid = OR of all in bits.
- err = 1 when popcount(in) >= 2; e still reports the priority winner.
- en = 0: e, valid, err hold previous values.

## Timing
- Latency: one clock; values of in and en sampled at rising edge N appear on outputs after edge N, stable until edge N+1.
- Reset: rst high at a rising edge forces e=2'b00, valid=0, err=0, overriding en. Reset mid-stream discards the sample taken at that edge; first valid result appears one edge after rst deasserts with en high.
- No combinational path from in to any output.
- No handshake; no backpressure. Input changes between edges are ignored.

## Configuration
- ENCODER_4TO2_ERR_EN defined: multi-hot detection compiled in; err behaves as in Operation.
- Not defined: detection logic omitted; err port remains and is driven constant 0 (reset and operation alike).

## Structure
- Shared package encoder_pkg: constant ENC_IN_W = 4, ENC_IDX_W = 2, typedef enc_idx_t (2-bit index), reset value constant ENC_IDX_RST = 2'b00.
- Sub-module encoder_4to2_core: purely combinational, ports in/e/valid/err, parameter PRIORITY_HIGH; top instantiates it and registers its outputs with en and rst.

## Test plan
- Reset: rst=1 for 2 cycles with in=4'b1111, en=1 -> e=00, valid=0, err=0 throughout; after release, next edge -> e=11, valid=1, err=1 (with macro).
- Exhaustive sweep, PRIORITY_HIGH=1: in = integer 0..15, one per cycle, en=1 -> e equals index of highest-numbered set bit, e.g. 5 (0101) -> e=11, 12 (1100) -> e=01, 0 -> valid=0.
- Exhaustive sweep, PRIORITY_HIGH=0: same stimulus -> 5 (0101) -> e=01, 3 (0011) -> e=10, 12 -> e=00.
- Enable hold: apply in=4'b0010 with en=1 (e=10), then in=4'b0001 with en=0 for 3 cycles -> e stays 10, valid stays 1.
- Multi-hot flag: in=4'b0110 -> err=1, e=10 (PRIORITY_HIGH=1); rebuild without ENCODER_4TO2_ERR_EN -> err=0.
- Latency: change in between edges -> outputs change only after the following rising edge.
